// File: rtl/dp_tap_pkg.sv
// Shared encodings for the debug-port TAP register file: instruction codes,
// bus FSM states and the default IDCODE value.
package dp_tap_pkg;

   localparam int IR_IDCODE   = 1;
   localparam int IR_DBG_ADDR = 2;
   localparam int IR_DBG_DATA = 3;
   localparam int IR_BYPASS   = -1;  // all-ones once cast to the IR width

   localparam logic [31:0] IDCODE_DEF = 32'h1000_0001;

   typedef enum logic {DBG_IDLE_S, DBG_REQ_S} dbg_state_e;

   typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_ADDR, DR_DATA} dr_sel_e;

endpackage

// File: rtl/dp_tap_registers_if.sv
// Single-word req/ack debug bus driven by the TAP register file.
interface dp_tap_registers_if #(parameter int DBG_W = 32) ();
   logic             dbg_req;
   logic             dbg_we;
   logic [DBG_W-1:0] dbg_addr;
   logic [DBG_W-1:0] dbg_wdata;
   logic             dbg_ack;
   logic [DBG_W-1:0] dbg_rdata;

   modport master (output dbg_req, dbg_we, dbg_addr, dbg_wdata,
                   input  dbg_ack, dbg_rdata);
   modport slave  (input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
                   output dbg_ack, dbg_rdata);
endinterface

// File: rtl/dp_tap_shreg.sv
// Generic TAP shift stage: parallel capture, or shift right with tdi into the MSB.
module dp_tap_shreg #(
   parameter int W = 1
) (
   input  logic         tck,
   input  logic         trst,
   input  logic         tdi,
   input  logic         capture,
   input  logic         shift,
   input  logic [W-1:0] cap_val,
   output logic [W-1:0] q
);

   logic [W-1:0] shift_nxt;

   generate
      if (W == 1) begin : g_one
         assign shift_nxt = tdi;
      end else begin : g_multi
         assign shift_nxt = {tdi, q[W-1:1]};
      end
   endgenerate

   always_ff @(posedge tck or negedge trst) begin
      if (!trst) begin
         q <= '0;
      end else if (capture) begin
         q <= cap_val;
      end else if (shift) begin
         q <= shift_nxt;
      end
   end

endmodule

// File: rtl/dp_tap_registers.sv
// Debug-port register file: IR, BYPASS/IDCODE/DBG_ADDR/DBG_DATA data registers,
// tdo mux and the req/ack bus sequencer.
//
//   state       | meaning
//   ------------+-------------------------------------------------
//   DBG_IDLE_S  | no transaction; a DBG_DATA update launches one
//   DBG_REQ_S   | dbg_req held with stable we/addr/wdata until ack
module dp_tap_registers
   import dp_tap_pkg::*;
#(
   parameter int          IR_W     = 4,
   parameter int          DBG_W    = 32,
   parameter logic [31:0] IDCODE_V = IDCODE_DEF
) (
   input  logic tck,
   input  logic trst,
   input  logic tdi,
   output logic tdo,
   input  logic sel_tdo,
   input  logic shift_ir,
   input  logic clk_ir,
   input  logic update_ir,
   input  logic shift_dr,
   input  logic clk_dr,
   input  logic update_dr,
   dp_tap_registers_if.master dbg
);

   dbg_state_e       state;
   dr_sel_e          dr_sel;
   logic [IR_W-1:0]  ir_q, ir_sh;
   logic [0:0]       byp_q;
   logic [31:0]      idcode_q;
   logic [DBG_W-1:0] addr_sh, addr_q, rdata_q;
   logic [DBG_W:0]   data_sh;
   logic             ovf, busy, dr_tdo;
   logic             cap_ir, sh_ir, cap_dr, sh_dr, upd_addr, upd_data;
   logic             unused_idcode;

   // update wins over a coincident clk strobe
   assign cap_ir = clk_ir & ~shift_ir & ~update_ir;
   assign sh_ir  = clk_ir &  shift_ir & ~update_ir;
   assign cap_dr = clk_dr & ~shift_dr & ~update_dr;
   assign sh_dr  = clk_dr &  shift_dr & ~update_dr;

   assign busy     = (state == DBG_REQ_S);
   assign upd_addr = update_dr & (dr_sel == DR_ADDR);
   assign upd_data = update_dr & (dr_sel == DR_DATA);

   always_comb begin
      dr_sel = DR_BYPASS;
      case (ir_q)
         IR_W'(IR_IDCODE):   dr_sel = DR_IDCODE;
         IR_W'(IR_DBG_ADDR): dr_sel = DR_ADDR;
         IR_W'(IR_DBG_DATA): dr_sel = DR_DATA;
         IR_W'(IR_BYPASS):   dr_sel = DR_BYPASS;
         default:            dr_sel = DR_BYPASS;
      endcase
   end

   dp_tap_shreg #(.W(IR_W)) u_ir (
      .tck(tck), .trst(trst), .tdi(tdi), .capture(cap_ir), .shift(sh_ir),
      .cap_val(IR_W'({ovf, 2'b01})), .q(ir_sh));

   dp_tap_shreg #(.W(1)) u_byp (
      .tck(tck), .trst(trst), .tdi(tdi),
      .capture(cap_dr & (dr_sel == DR_BYPASS)), .shift(sh_dr & (dr_sel == DR_BYPASS)),
      .cap_val(1'b0), .q(byp_q));

   dp_tap_shreg #(.W(32)) u_idcode (
      .tck(tck), .trst(trst), .tdi(tdi),
      .capture(cap_dr & (dr_sel == DR_IDCODE)), .shift(sh_dr & (dr_sel == DR_IDCODE)),
      .cap_val(IDCODE_V), .q(idcode_q));

   dp_tap_shreg #(.W(DBG_W)) u_addr (
      .tck(tck), .trst(trst), .tdi(tdi),
      .capture(cap_dr & (dr_sel == DR_ADDR)), .shift(sh_dr & (dr_sel == DR_ADDR)),
      .cap_val(addr_q), .q(addr_sh));

   dp_tap_shreg #(.W(DBG_W + 1)) u_data (
      .tck(tck), .trst(trst), .tdi(tdi),
      .capture(cap_dr & (dr_sel == DR_DATA)), .shift(sh_dr & (dr_sel == DR_DATA)),
      .cap_val({rdata_q, busy}), .q(data_sh));

   assign unused_idcode = ^idcode_q[31:1];

   always_ff @(posedge tck or negedge trst) begin
      if (!trst) begin
         state         <= DBG_IDLE_S;
         ir_q          <= IR_W'(IR_IDCODE);
         addr_q        <= '0;
         rdata_q       <= '0;
         ovf           <= 1'b0;
         dbg.dbg_req   <= 1'b0;
         dbg.dbg_we    <= 1'b0;
         dbg.dbg_wdata <= '0;
      end else begin
         if (update_ir) begin
            ir_q <= ir_sh;
            ovf  <= 1'b0;
         end
         if (upd_data && busy) ovf <= 1'b1;
         // address must stay stable on the bus while a request is open
         if (upd_addr && !busy) addr_q <= addr_sh;

         case (state)
            DBG_IDLE_S: begin
               if (upd_data) begin
                  dbg.dbg_we    <= data_sh[0];
                  dbg.dbg_wdata <= data_sh[DBG_W:1];
                  dbg.dbg_req   <= 1'b1;
                  state         <= DBG_REQ_S;
               end
            end
            DBG_REQ_S: begin
               if (dbg.dbg_ack) begin
                  if (!dbg.dbg_we) rdata_q <= dbg.dbg_rdata;
                  addr_q      <= addr_q + DBG_W'(4);
                  dbg.dbg_req <= 1'b0;
                  state       <= DBG_IDLE_S;
               end
            end
            default: state <= DBG_IDLE_S;
         endcase
      end
   end

   assign dbg.dbg_addr = addr_q;

   always_comb begin
      dr_tdo = byp_q[0];
      case (dr_sel)
         DR_IDCODE: dr_tdo = idcode_q[0];
         DR_ADDR:   dr_tdo = addr_sh[0];
         DR_DATA:   dr_tdo = data_sh[0];
         default:   dr_tdo = byp_q[0];
      endcase
   end

   assign tdo = sel_tdo ? ir_sh[0] : dr_tdo;

endmodule

// File: tb/tb_dp_tap_registers.sv
// Self-checking bench for dp_tap_registers: instruction table, directed bus
// sequences and a randomized bus run against a simple address/readback model.
module tb_dp_tap_registers;

   logic tck = 1'b0;
   logic trst = 1'b0;
   logic tdi = 1'b0;
   logic tdo;
   logic sel_tdo = 1'b0;
   logic shift_ir = 1'b0, clk_ir = 1'b0, update_ir = 1'b0;
   logic shift_dr = 1'b0, clk_dr = 1'b0, update_dr = 1'b0;

   dp_tap_registers_if #(.DBG_W(32)) dbg ();

   dp_tap_registers #(.IR_W(4), .DBG_W(32), .IDCODE_V(32'h1000_0001)) dut (
      .tck(tck), .trst(trst), .tdi(tdi), .tdo(tdo), .sel_tdo(sel_tdo),
      .shift_ir(shift_ir), .clk_ir(clk_ir), .update_ir(update_ir),
      .shift_dr(shift_dr), .clk_dr(clk_dr), .update_dr(update_dr),
      .dbg(dbg));

   always #5 tck = ~tck;

   localparam logic [31:0] IDCODE = 32'h1000_0001;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0]  ir;
      int          n;
      logic [32:0] exp;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge tck);
      @(negedge tck);
   endtask

   task automatic ir_scan(input logic [3:0] val, output logic [3:0] cap);
      cap = '0;
      sel_tdo = 1'b1;
      clk_ir = 1'b1; shift_ir = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         cap[i] = tdo;
         shift_ir = 1'b1; clk_ir = 1'b1; tdi = val[i];
         step();
      end
      shift_ir = 1'b0; clk_ir = 1'b0;
      update_ir = 1'b1;
      step();
      update_ir = 1'b0;
      sel_tdo = 1'b0;
   endtask

   task automatic dr_scan(input int n, input logic [32:0] din, input bit upd,
                          output logic [32:0] cap);
      cap = '0;
      sel_tdo = 1'b0;
      clk_dr = 1'b1; shift_dr = 1'b0;
      step();
      for (int i = 0; i < n; i++) begin
         cap[i] = tdo;
         shift_dr = 1'b1; clk_dr = 1'b1; tdi = din[i];
         step();
      end
      shift_dr = 1'b0; clk_dr = 1'b0;
      if (upd) begin
         update_dr = 1'b1;
         step();
         update_dr = 1'b0;
      end
   endtask

   task automatic set_addr(input logic [31:0] a);
      logic [3:0]  c4;
      logic [32:0] c;
      ir_scan(4'd2, c4);
      dr_scan(32, {1'b0, a}, 1'b1, c);
   endtask

   task automatic read_addr(output logic [31:0] a);
      logic [3:0]  c4;
      logic [32:0] c;
      ir_scan(4'd2, c4);
      dr_scan(32, {1'b0, $urandom}, 1'b0, c);
      a = c[31:0];
   endtask

   // Launch one transaction and ack it after lat waiting cycles.
   task automatic access(input logic [31:0] data, input logic we, input int lat,
                         input logic [31:0] rd, input logic [31:0] exp_addr);
      logic [3:0]  c4;
      logic [32:0] c;
      ir_scan(4'd3, c4);
      dr_scan(33, {data, we}, 1'b1, c);
      chk("req_rise", dbg.dbg_req, 1'b1);
      chk("req_we", dbg.dbg_we, we);
      chk("req_addr", dbg.dbg_addr, exp_addr);
      chk("req_wdata", dbg.dbg_wdata, data);
      for (int i = 0; i < lat; i++) begin
         step();
         chk("req_hold", dbg.dbg_req, 1'b1);
      end
      dbg.dbg_ack = 1'b1; dbg.dbg_rdata = rd;
      step();
      dbg.dbg_ack = 1'b0; dbg.dbg_rdata = $urandom;
      chk("req_fall", dbg.dbg_req, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  c4;
      logic [32:0] c;
      logic [31:0] a, model_addr, model_rdata, d, rd;
      logic        we;
      int          lat;

      vecs[0] = '{ir: 4'h1, n: 32, exp: {1'b0, IDCODE}};
      vecs[1] = '{ir: 4'h0, n: 1,  exp: 33'd0};
      vecs[2] = '{ir: 4'h2, n: 32, exp: 33'd0};
      vecs[3] = '{ir: 4'h3, n: 33, exp: 33'd0};
      vecs[4] = '{ir: 4'h4, n: 1,  exp: 33'd0};
      vecs[5] = '{ir: 4'h7, n: 1,  exp: 33'd0};
      vecs[6] = '{ir: 4'h8, n: 1,  exp: 33'd0};
      vecs[7] = '{ir: 4'hF, n: 1,  exp: 33'd0};

      dbg.dbg_ack = 1'b0;
      dbg.dbg_rdata = '0;
      repeat (3) @(negedge tck);
      chk("rst_req", dbg.dbg_req, 1'b0);
      chk("rst_we", dbg.dbg_we, 1'b0);
      chk("rst_addr", dbg.dbg_addr, 32'd0);
      chk("rst_wdata", dbg.dbg_wdata, 32'd0);
      trst = 1'b1;
      step();

      // IR comes out of reset holding IDCODE
      dr_scan(32, {1'b0, $urandom}, 1'b0, c);
      chk("rst_idcode", c[31:0], IDCODE);

      for (int v = 0; v < 8; v++) begin
         logic [32:0] mask;
         ir_scan(vecs[v].ir, c4);
         chk("tbl_ir_cap", c4, 4'b0001);
         dr_scan(vecs[v].n, {$urandom, 1'b0}, 1'b0, c);
         mask = (33'd1 << vecs[v].n) - 33'd1;
         chk("tbl_dr_cap", c & mask, vecs[v].exp & mask);
      end

      // BYPASS delays tdi by one bit behind a captured 0
      ir_scan(4'hF, c4);
      ir_scan(4'hF, c4);
      chk("ir_cap_seq", c4, 4'b0001);
      dr_scan(4, 33'b1101, 1'b0, c);
      chk("bypass_seq", c[3:0], 4'b1010);

      set_addr(32'h100);
      access(32'hDEAD_BEEF, 1'b1, 3, 32'h5555_AAAA, 32'h100);
      read_addr(a);
      chk("write_addr_inc", a, 32'h104);

      access(32'h0BAD_F00D, 1'b0, 0, 32'h1234_5678, 32'h104);
      ir_scan(4'd3, c4);
      dr_scan(33, 33'd0, 1'b0, c);
      chk("read_cap", c, {32'h1234_5678, 1'b0});

      // second DATA update while busy is dropped and flags overrun
      set_addr(32'h200);
      ir_scan(4'd3, c4);
      dr_scan(33, {32'h1111_1111, 1'b1}, 1'b1, c);
      chk("ovr_req1", dbg.dbg_req, 1'b1);
      dr_scan(33, {32'h2222_2222, 1'b0}, 1'b1, c);
      chk("ovr_busy_cap", c[0], 1'b1);
      chk("ovr_req_held", dbg.dbg_req, 1'b1);
      chk("ovr_wdata", dbg.dbg_wdata, 32'h1111_1111);
      chk("ovr_we", dbg.dbg_we, 1'b1);
      dbg.dbg_ack = 1'b1;
      step();
      dbg.dbg_ack = 1'b0;
      step();
      chk("ovr_no_new_req", dbg.dbg_req, 1'b0);
      ir_scan(4'd3, c4);
      chk("ovf_set", c4, 4'b0101);
      ir_scan(4'd3, c4);
      chk("ovf_clear", c4, 4'b0001);

      set_addr(32'hFFFF_FFFC);
      access(32'h0, 1'b0, 1, 32'hCAFE_F00D, 32'hFFFF_FFFC);
      read_addr(a);
      chk("addr_wrap", a, 32'h0);

      // reset while a request is open
      set_addr(32'h300);
      ir_scan(4'd3, c4);
      dr_scan(33, {32'hAAAA_5555, 1'b1}, 1'b1, c);
      chk("mid_req", dbg.dbg_req, 1'b1);
      trst = 1'b0;
      #1;
      chk("mid_rst_req", dbg.dbg_req, 1'b0);
      chk("mid_rst_addr", dbg.dbg_addr, 32'h0);
      @(negedge tck);
      trst = 1'b1;
      dbg.dbg_ack = 1'b1; dbg.dbg_rdata = 32'h7777_7777;
      step();
      dbg.dbg_ack = 1'b0;
      chk("mid_ack_ign_req", dbg.dbg_req, 1'b0);
      chk("mid_ack_ign_addr", dbg.dbg_addr, 32'h0);
      dr_scan(32, {1'b0, $urandom}, 1'b0, c);
      chk("mid_ir_idcode", c[31:0], IDCODE);

      // randomized bus traffic against an address/readback model
      model_addr  = 32'h0;
      model_rdata = 32'h0;
      for (int it = 0; it < 20; it++) begin
         if ($urandom_range(0, 1) == 1) begin
            a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                            : ($urandom & 32'hFFFF_FFFC);
            set_addr(a);
            model_addr = a;
         end
         we  = $urandom_range(0, 1) == 1;
         d   = $urandom;
         rd  = $urandom;
         lat = $urandom_range(0, 3);
         access(d, we, lat, rd, model_addr);
         if (!we) model_rdata = rd;
         model_addr = model_addr + 32'd4;
         ir_scan(4'd3, c4);
         dr_scan(33, 33'd0, 1'b0, c);
         chk("rnd_data_cap", c, {model_rdata, 1'b0});
         read_addr(a);
         chk("rnd_addr", a, model_addr);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dp_tap_registers.md
# dp_tap_registers

Debug-port register file consuming the TAP controller's strobes (`shift_ir`, `clk_ir`, `update_ir`, `shift_dr`, `clk_dr`, `update_dr`, `sel_tdo`). It holds the instruction register, decodes it, and implements the BYPASS, IDCODE, DBG_ADDR and DBG_DATA data registers. It drives `tdo` and issues single-word read/write transactions on a simple req/ack debug bus in the `tck` domain.

## Interface
- `IR_W`, 4: instruction register width; must be ≥ 3.
- `DBG_W`, 32: debug address/data width.
- `IDCODE_V`, 32'h1000_0001: IDCODE value; bit 0 must be 1.
- `tck` in 1: sole clock; all state updates on posedge.
- `trst` in 1: asynchronous, active-low reset.
- `tdi` in 1: serial data in.
- `tdo` out 1: serial data out; combinational from register LSBs.
- `sel_tdo` in 1: 1 selects the IR path, 0 selects the DR path.
- `shift_ir`, `clk_ir`, `update_ir` in 1 each: IR strobes from the TAP controller.
- `shift_dr`, `clk_dr`, `update_dr` in 1 each: DR strobes from the TAP controller.
- `dbg_req` out 1: bus request.
- `dbg_we` out 1: 1 = write.
- `dbg_addr` out DBG_W: bus address.
- `dbg_wdata` out DBG_W: write data.
- `dbg_ack` in 1: one-cycle completion strobe.
- `dbg_rdata` in DBG_W: read data; valid with `dbg_ack`.

## Operation
- **Strobe decode**, per register group, on posedge `tck`:
  - `clk_x & !shift_x`: capture.
  - `clk_x & shift_x`: shift right, `tdi` into the MSB.
  - `update_x`: update.
  - `clk_x` and `update_x` are never both high; if they are, update wins.
- **IR**:
  - Capture loads `{0…, ovf, 1'b0, 1'b1}`.
  - Update copies the shift stage into `ir_q` and clears `ovf`.
- **Instruction decode of `ir_q`**:
  - 1 = IDCODE.
  - 2 = DBG_ADDR.
  - 3 = DBG_DATA.
  - All-ones and every unlisted code = BYPASS.
- **BYPASS**: 1-bit register; capture loads 0.
- **IDCODE**: 32-bit register; capture loads `IDCODE_V`; update has no effect.
- **DBG_ADDR**: DBG_W bits.
  - Capture loads `addr_q`.
  - Update loads `addr_q` from the shift stage.
- **DBG_DATA**: DBG_W+1 bits, laid out `{data, we}`.
  - Capture loads `{rdata_q, busy}`.
  - Update when not busy: latch `dbg_we` = bit 0 and `dbg_wdata` = bits [DBG_W:1], then enter REQ.
  - Update when busy: dropped; sets sticky `ovf`.
- **Bus FSM**:
  - IDLE → REQ on an accepted DBG_DATA update.
  - REQ holds `dbg_req`=1 with `dbg_we`, `dbg_addr` (= `addr_q`) and `dbg_wdata` stable until `dbg_ack`.
  - On `dbg_ack`:
    - A read stores `dbg_rdata` into `rdata_q`; a write leaves `rdata_q` unchanged.
    - `addr_q` += 4, modulo 2^DBG_W; wraps from all-ones-minus-3 to 0.
    - FSM → IDLE.
  - `busy` = (state == REQ).
- **`tdo` mux**:
  - `sel_tdo`=1: IR shift-stage bit 0.
  - `sel_tdo`=0: bit 0 of the DR selected by `ir_q`.
- **Reset** (`trst` low, asynchronous, any time including mid-transaction):
  - FSM returns to IDLE.
  - `ir_q` = IDCODE (1).
  - All shift stages, `addr_q`, `rdata_q` and `ovf` = 0.
  - Outputs: `dbg_req`=0, `dbg_we`=0, `dbg_addr`=0, `dbg_wdata`=0.
  - A pending `dbg_ack` after reset is ignored.

## Timing
- Capture, shift and update each take effect on the posedge where the strobe is sampled high.
- `tdo` reflects the new LSB in the same cycle, after that edge.
- **Request latency**: `dbg_req` rises one cycle after the posedge sampling the DBG_DATA `update_dr`.
- **Ack handling**:
  - `dbg_ack` in the same cycle `dbg_req` first rises is accepted.
  - `dbg_req` falls the edge after ack; minimum transaction is 1 cycle.
  - Back-to-back requests need a fresh update, so there is no combinational req→req path.
- **Simultaneous update and ack**: an update sampled on the same edge as `dbg_ack` counts as busy, so it is dropped and `ovf` is set.
- **Decode source**: instruction decode uses `ir_q` only; an IR shift in progress does not change DR selection.

## Structure
- Package `dp_tap_pkg`:
  - Instruction encodings: `IR_IDCODE`, `IR_DBG_ADDR`, `IR_DBG_DATA`, `IR_BYPASS`.
  - Bus FSM enum `{DBG_IDLE_S, DBG_REQ_S}`.
  - Default `IDCODE_V`.
- Sub-module `dp_tap_shreg #(W)`:
  - Ports: `tck`, `trst`, `tdi`, `capture`, `shift`, `cap_val`, `q`.
  - Used for IR, BYPASS, IDCODE, ADDR and DATA.
- Bus FSM and `tdo` mux live in the top level.

## Test plan
- **Reset IDCODE**: pulse `trst`; with IR at reset, capture+shift 32 DR bits → `tdo` serializes 32'h1000_0001 LSB first.
- **IR capture and BYPASS**: shift IR=4'hF; IR capture shows `tdo` sequence 1,0,0,0. DR shift of `tdi` 1,0,1,1 → `tdo` 0,1,0,1 (one-cycle delay).
- **Write**:
  - Stimulus: load ADDR=32'h100, then DATA `{32'hDEAD_BEEF, 1}`.
  - Required: `dbg_req` next cycle, `dbg_we`=1, `dbg_addr`=32'h100, `dbg_wdata`=32'hDEAD_BEEF.
  - Ack after 3 cycles → `dbg_req` drops; ADDR capture reads 32'h104.
- **Read**: DATA update `{x, 0}`, ack with `dbg_rdata`=32'h1234_5678; next DATA capture shifts out busy=0 then 32'h1234_5678.
- **Overrun and wrap**:
  - Second DATA update while `dbg_req` is held → no new request; IR capture bit 2 = 1; IR update clears it.
  - ADDR=32'hFFFF_FFFC, one access → ADDR reads 0.
- **Reset mid-transaction**: assert `trst` during REQ → `dbg_req`=0 immediately; later `dbg_ack` ignored; `ir_q`=IDCODE.
